// File: rtl/ddr_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr_req_arbiter
// Purpose  : Latches read (line-fill) and write (write-through) request pulses
//            from the data cache and serves them one at a time over a
//            MIG-style DDR application interface. Returns a one-cycle fin
//            pulse per completed request, with the line on reads.
// Ports    : clk, rst                       clock, synchronous active-high reset
//            cache2DDR_rd_* / DDR2cache_rd_* read request channel and completion
//            cache2DDR_wr_* / DDR2cache_wr_fin write request channel and completion
//            init_calib_complete            controller ready gate
//            app_*                          DDR application interface
//            err_overrun                    sticky: same-type request while busy
// Macro    : DDR_ARB_RD_FIRST_EN  defined -> pending read wins the IDLE tie-break;
//                                 undefined -> pending write wins (default)
// Revision : 1.0  initial release
// ============================================================================
module ddr_req_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic [26:0]  cache2DDR_rd_addr,
  input  logic         cache2DDR_rd_en,
  output logic         DDR2cache_rd_fin,
  output logic [127:0] DDR2cache_rd_data,
  input  logic [26:0]  cache2DDR_wr_addr,
  input  logic [127:0] cache2DDR_wr_data,
  input  logic         cache2DDR_wr_en,
  output logic         DDR2cache_wr_fin,
  input  logic         init_calib_complete,
  output logic [26:0]  app_addr,
  output logic [2:0]   app_cmd,
  output logic         app_en,
  input  logic         app_rdy,
  output logic [127:0] app_wdf_data,
  output logic         app_wdf_wren,
  output logic         app_wdf_end,
  output logic [15:0]  app_wdf_mask,
  input  logic         app_wdf_rdy,
  input  logic [127:0] app_rd_data,
  input  logic         app_rd_data_valid,
  output logic         err_overrun
);

  localparam logic [2:0]  C_CMD_RD    = 3'b001;
  localparam logic [2:0]  C_CMD_WR    = 3'b000;
  localparam logic [26:0] C_LINE_MASK = 27'h7FF_FFF0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_CMD  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_RD_DONE = 3'd3,
    S_WR_CMD  = 3'd4,
    S_WR_DONE = 3'd5
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_rd_pend;
  logic [26:0]    r_rd_addr;
  logic           r_wr_pend;
  logic [26:0]    r_wr_addr;
  logic [127:0]   r_wr_data;
  logic           r_cmd_acc;   // write command already accepted this transaction
  logic           r_dat_acc;   // write data already accepted this transaction
  logic [127:0]   r_rd_data;
  logic           r_err;
  logic           w_cmd_done;
  logic           w_dat_done;

  // Next-state and output decode
  always_comb begin
    w_next           = r_state;
    app_en           = 1'b0;
    app_cmd          = C_CMD_WR;
    app_addr         = 27'd0;
    app_wdf_wren     = 1'b0;
    app_wdf_data     = 128'd0;
    DDR2cache_rd_fin = 1'b0;
    DDR2cache_wr_fin = 1'b0;
    w_cmd_done       = r_cmd_acc || app_rdy;
    w_dat_done       = r_dat_acc || app_wdf_rdy;
    case (r_state)
      S_IDLE: begin
        if (init_calib_complete && (r_rd_pend || r_wr_pend)) begin
`ifdef DDR_ARB_RD_FIRST_EN
          w_next = r_rd_pend ? S_RD_CMD : S_WR_CMD;
`else
          w_next = r_wr_pend ? S_WR_CMD : S_RD_CMD;
`endif
        end
      end
      S_RD_CMD: begin
        app_en   = 1'b1;
        app_cmd  = C_CMD_RD;
        app_addr = r_rd_addr & C_LINE_MASK;
        if (app_rdy) w_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (app_rd_data_valid) w_next = S_RD_DONE;
      end
      S_RD_DONE: begin
        DDR2cache_rd_fin = 1'b1;
        w_next           = S_IDLE;
      end
      S_WR_CMD: begin
        // Command and data handshakes complete independently; each strobe
        // drops once its own ready has been seen.
        app_en       = !r_cmd_acc;
        app_cmd      = C_CMD_WR;
        app_addr     = r_wr_addr & C_LINE_MASK;
        app_wdf_wren = !r_dat_acc;
        app_wdf_data = r_wr_data;
        if (w_cmd_done && w_dat_done) w_next = S_WR_DONE;
      end
      S_WR_DONE: begin
        DDR2cache_wr_fin = 1'b1;
        w_next           = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rd_pend <= 1'b0;
      r_rd_addr <= 27'd0;
      r_wr_pend <= 1'b0;
      r_wr_addr <= 27'd0;
      r_wr_data <= 128'd0;
      r_cmd_acc <= 1'b0;
      r_dat_acc <= 1'b0;
      r_rd_data <= 128'd0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;

      // Pend stays set through service, so a second pulse while busy is an overrun.
      if (cache2DDR_rd_en) begin
        if (r_rd_pend) begin
          r_err <= 1'b1;
        end else begin
          r_rd_pend <= 1'b1;
          r_rd_addr <= cache2DDR_rd_addr;
        end
      end
      if (cache2DDR_wr_en) begin
        if (r_wr_pend) begin
          r_err <= 1'b1;
        end else begin
          r_wr_pend <= 1'b1;
          r_wr_addr <= cache2DDR_wr_addr;
          r_wr_data <= cache2DDR_wr_data;
        end
      end

      // Read data is only meaningful while waiting for it.
      if (r_state == S_RD_WAIT && app_rd_data_valid) begin
        r_rd_data <= app_rd_data;
        r_rd_pend <= 1'b0;
      end

      if (r_state == S_WR_CMD && w_next == S_WR_CMD) begin
        r_cmd_acc <= w_cmd_done;
        r_dat_acc <= w_dat_done;
      end else begin
        r_cmd_acc <= 1'b0;
        r_dat_acc <= 1'b0;
      end
      if (r_state == S_WR_CMD && w_next == S_WR_DONE) r_wr_pend <= 1'b0;
    end
  end

  assign app_wdf_end       = app_wdf_wren;
  assign app_wdf_mask      = 16'd0;
  assign DDR2cache_rd_data = r_rd_data;
  assign err_overrun       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_req_arbiter
// Purpose  : Self-checking bench for ddr_req_arbiter. Expected commands,
//            write data and read lines are queued when stimulus is driven and
//            consumed by a monitor as the DUT produces them.
// Revision : 1.0  initial release
// ============================================================================
module tb_ddr_req_arbiter;

  logic         clk;
  logic         rst;
  logic [26:0]  cache2DDR_rd_addr;
  logic         cache2DDR_rd_en;
  logic         DDR2cache_rd_fin;
  logic [127:0] DDR2cache_rd_data;
  logic [26:0]  cache2DDR_wr_addr;
  logic [127:0] cache2DDR_wr_data;
  logic         cache2DDR_wr_en;
  logic         DDR2cache_wr_fin;
  logic         init_calib_complete;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         err_overrun;

  ddr_req_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .cache2DDR_rd_addr   (cache2DDR_rd_addr),
    .cache2DDR_rd_en     (cache2DDR_rd_en),
    .DDR2cache_rd_fin    (DDR2cache_rd_fin),
    .DDR2cache_rd_data   (DDR2cache_rd_data),
    .cache2DDR_wr_addr   (cache2DDR_wr_addr),
    .cache2DDR_wr_data   (cache2DDR_wr_data),
    .cache2DDR_wr_en     (cache2DDR_wr_en),
    .DDR2cache_wr_fin    (DDR2cache_wr_fin),
    .init_calib_complete (init_calib_complete),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .err_overrun         (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rd_fin_cnt = 0;
  int wr_fin_cnt = 0;

  logic [29:0]  exp_cmd_q[$];   // {app_cmd, app_addr}
  logic [127:0] exp_wdat_q[$];
  logic [127:0] exp_rd_q[$];
  logic [29:0]  mon_cmd;
  logic [127:0] mon_dat;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: consumes scoreboard entries as the DUT completes handshakes.
  always @(negedge clk) begin
    if (!rst) begin
      if (app_en && app_rdy) begin
        chk("cmd_expected", 128'(exp_cmd_q.size() != 0), 128'(1));
        if (exp_cmd_q.size() != 0) begin
          mon_cmd = exp_cmd_q.pop_front();
          chk("cmd_addr", 128'({app_cmd, app_addr}), 128'(mon_cmd));
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        chk("wdat_expected", 128'(exp_wdat_q.size() != 0), 128'(1));
        if (exp_wdat_q.size() != 0) begin
          mon_dat = exp_wdat_q.pop_front();
          chk("wdf_data", app_wdf_data, mon_dat);
          chk("wdf_end", 128'(app_wdf_end), 128'(app_wdf_wren));
        end
      end
      if (DDR2cache_rd_fin) begin
        rd_fin_cnt++;
        chk("rd_expected", 128'(exp_rd_q.size() != 0), 128'(1));
        if (exp_rd_q.size() != 0) begin
          mon_dat = exp_rd_q.pop_front();
          chk("rd_data", DDR2cache_rd_data, mon_dat);
        end
      end
      if (DDR2cache_wr_fin) wr_fin_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the read command to be on the bus with app_rdy high.
  task automatic wait_rd_cmd();
    int n;
    n = 0;
    while (!(app_en && app_cmd == 3'b001 && app_rdy) && n < 30) begin
      step();
      n++;
    end
    chk("rd_cmd_timeout", 128'(n < 30), 128'(1));
  endtask

  // Accept the read command, then return the line one wait cycle later.
  task automatic serve_read(input logic [127:0] d);
    wait_rd_cmd();
    step();
    step();
    app_rd_data       = d;
    app_rd_data_valid = 1'b1;
    exp_rd_q.push_back(d);
    step();
    app_rd_data_valid = 1'b0;
  endtask

  task automatic wait_fins(input int rd_exp, input int wr_exp);
    int n;
    n = 0;
    while ((rd_fin_cnt < rd_exp || wr_fin_cnt < wr_exp) && n < 30) begin
      step();
      n++;
    end
    repeat (3) step();
    chk("rd_fin_count", 128'(rd_fin_cnt), 128'(rd_exp));
    chk("wr_fin_count", 128'(wr_fin_cnt), 128'(wr_exp));
  endtask

  initial begin
    int en_cnt;
    int wren_cnt;
    int fin_c;
    logic [127:0] d1, wd2, d3, wd3, d4, dstray, d5;
    d1     = {16{8'hA5}};
    wd2    = {8{16'h1111}};
    d3     = {4{32'hDEADBEEF}};
    wd3    = {8{16'h2222}};
    d4     = {4{32'h0BADF00D}};
    dstray = {4{32'hFFFF0000}};
    d5     = {4{32'h12345678}};

    rst = 1'b1;
    cache2DDR_rd_addr = '0; cache2DDR_rd_en = 1'b0;
    cache2DDR_wr_addr = '0; cache2DDR_wr_data = '0; cache2DDR_wr_en = 1'b0;
    init_calib_complete = 1'b1;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    app_rd_data = '0; app_rd_data_valid = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_app_en", 128'(app_en), 128'(0));
    chk("rst_app_cmd", 128'(app_cmd), 128'(0));
    chk("rst_app_addr", 128'(app_addr), 128'(0));
    chk("rst_wdf_wren", 128'(app_wdf_wren), 128'(0));
    chk("rst_rd_fin", 128'(DDR2cache_rd_fin), 128'(0));
    chk("rst_wr_fin", 128'(DDR2cache_wr_fin), 128'(0));
    chk("rst_err", 128'(err_overrun), 128'(0));
    chk("rst_wdf_mask", 128'(app_wdf_mask), 128'(0));
    rst = 1'b0;
    step();

    // ---- Read ----
    cache2DDR_rd_addr = 27'h0001234;
    cache2DDR_rd_en   = 1'b1;
    exp_cmd_q.push_back({3'b001, 27'h0001230});
    step();
    cache2DDR_rd_en = 1'b0;
    chk("rd_c1_app_en", 128'(app_en), 128'(0));
    step();
    chk("rd_c2_app_en", 128'(app_en), 128'(1));
    chk("rd_c2_cmd", 128'(app_cmd), 128'(3'b001));
    chk("rd_c2_addr", 128'(app_addr), 128'(27'h0001230));
    step();
    chk("rd_c3_app_en", 128'(app_en), 128'(0));
    step();
    step();
    app_rd_data = d1; app_rd_data_valid = 1'b1;
    exp_rd_q.push_back(d1);
    step();
    app_rd_data_valid = 1'b0;
    chk("rd_fin_kp1", 128'(DDR2cache_rd_fin), 128'(1));
    chk("rd_data_kp1", DDR2cache_rd_data, d1);
    step();
    chk("rd_fin_single", 128'(DDR2cache_rd_fin), 128'(0));
    chk("rd_data_held", DDR2cache_rd_data, d1);

    // ---- Write with split readies ----
    app_rdy = 1'b0;
    cache2DDR_wr_addr = 27'h0000040;
    cache2DDR_wr_data = wd2;
    cache2DDR_wr_en   = 1'b1;
    exp_cmd_q.push_back({3'b000, 27'h0000040});
    exp_wdat_q.push_back(wd2);
    step();
    cache2DDR_wr_en = 1'b0;
    step();
    chk("wr_c2_cmd", 128'(app_cmd), 128'(3'b000));
    chk("wr_c2_addr", 128'(app_addr), 128'(27'h0000040));
    chk("wr_c2_wren", 128'(app_wdf_wren), 128'(1));
    en_cnt = 0; wren_cnt = 0; fin_c = -1;
    for (int c = 2; c <= 8; c++) begin
      app_rdy = (c == 6);
      en_cnt   += int'(app_en);
      wren_cnt += int'(app_wdf_wren);
      if (DDR2cache_wr_fin) fin_c = c;
      step();
    end
    app_rdy = 1'b1;
    chk("wr_app_en_cycles", 128'(en_cnt), 128'(5));
    chk("wr_wren_cycles", 128'(wren_cnt), 128'(1));
    chk("wr_fin_cycle", 128'(fin_c), 128'(7));
    chk("wr_fin_count_1", 128'(wr_fin_cnt), 128'(1));

    // ---- Simultaneous pulses ----
    cache2DDR_rd_addr = 27'h0000105;
    cache2DDR_wr_addr = 27'h0000200;
    cache2DDR_wr_data = wd3;
    cache2DDR_rd_en = 1'b1;
    cache2DDR_wr_en = 1'b1;
`ifdef DDR_ARB_RD_FIRST_EN
    exp_cmd_q.push_back({3'b001, 27'h0000100});
    exp_cmd_q.push_back({3'b000, 27'h0000200});
`else
    exp_cmd_q.push_back({3'b000, 27'h0000200});
    exp_cmd_q.push_back({3'b001, 27'h0000100});
`endif
    exp_wdat_q.push_back(wd3);
    step();
    cache2DDR_rd_en = 1'b0;
    cache2DDR_wr_en = 1'b0;
    step();
    chk("sim_first_en", 128'(app_en), 128'(1));
`ifdef DDR_ARB_RD_FIRST_EN
    chk("sim_first_cmd", 128'(app_cmd), 128'(3'b001));
`else
    chk("sim_first_cmd", 128'(app_cmd), 128'(3'b000));
`endif
    serve_read(d3);
    wait_fins(2, 2);

    // ---- Calibration gating and overrun ----
    init_calib_complete = 1'b0;
    cache2DDR_rd_addr = 27'h000030C;
    cache2DDR_rd_en   = 1'b1;
    exp_cmd_q.push_back({3'b001, 27'h0000300});
    step();
    cache2DDR_rd_en = 1'b0;
    step();
    chk("cal_err_before", 128'(err_overrun), 128'(0));
    cache2DDR_rd_addr = 27'h0000400;
    cache2DDR_rd_en   = 1'b1;
    step();
    cache2DDR_rd_en = 1'b0;
    step();
    step();
    chk("cal_no_app_en", 128'(app_en), 128'(0));
    chk("cal_err_set", 128'(err_overrun), 128'(1));
    init_calib_complete = 1'b1;
    serve_read(d4);
    wait_fins(3, 2);
    chk("cal_err_sticky", 128'(err_overrun), 128'(1));

    // ---- Reset mid-read ----
    cache2DDR_rd_addr = 27'h0000500;
    cache2DDR_rd_en   = 1'b1;
    exp_cmd_q.push_back({3'b001, 27'h0000500});
    step();
    cache2DDR_rd_en = 1'b0;
    wait_rd_cmd();
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_app_en", 128'(app_en), 128'(0));
    chk("mid_rst_cmd", 128'(app_cmd), 128'(0));
    chk("mid_rst_addr", 128'(app_addr), 128'(0));
    chk("mid_rst_wren", 128'(app_wdf_wren), 128'(0));
    chk("mid_rst_rd_data", DDR2cache_rd_data, 128'd0);
    chk("mid_rst_err", 128'(err_overrun), 128'(0));
    rst = 1'b0;
    app_rd_data = dstray; app_rd_data_valid = 1'b1;
    step();
    app_rd_data_valid = 1'b0;
    step();
    step();
    chk("mid_rst_no_fin", 128'(rd_fin_cnt), 128'(3));
    chk("mid_rst_idle_en", 128'(app_en), 128'(0));
    cache2DDR_rd_addr = 27'h0000600;
    cache2DDR_rd_en   = 1'b1;
    exp_cmd_q.push_back({3'b001, 27'h0000600});
    step();
    cache2DDR_rd_en = 1'b0;
    serve_read(d5);
    wait_fins(4, 2);

    chk("cmd_q_drained", 128'(exp_cmd_q.size()), 128'(0));
    chk("wdat_q_drained", 128'(exp_wdat_q.size()), 128'(0));
    chk("rd_q_drained", 128'(exp_rd_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ddr_req_arbiter.md
# ddr_req_arbiter

Sits directly downstream of the data cache and serves its two independent line-fill (read) and write-through (write) request channels over one MIG-style DDR application interface. Latches one-cycle request pulses from the cache and arbitrates between a pending read and a pending write. Issues one 128-bit command at a time. Returns a one-cycle `fin` pulse to the cache per completed request, with the 128-bit line on reads.

## Interface
- `RD_FIRST`, from macro: arbitration winner when both requests are pending; see Configuration.
- `clk`  in  1  sole clock; everything rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `cache2DDR_rd_addr`  in  27  byte address of the line to read; bits [3:0] ignored.
- `cache2DDR_rd_en`  in  1  one-cycle read request pulse.
- `DDR2cache_rd_fin`  out  1  one-cycle pulse: read data valid.
- `DDR2cache_rd_data`  out  128  read line; held until the next read completes.
- `cache2DDR_wr_addr`  in  27  byte address of the line to write; bits [3:0] ignored.
- `cache2DDR_wr_data`  in  128  full line to write.
- `cache2DDR_wr_en`  in  1  one-cycle write request pulse.
- `DDR2cache_wr_fin`  out  1  one-cycle pulse: command and data accepted by the controller.
- `init_calib_complete`  in  1  controller ready; no command is issued while low.
- `app_addr`  out  27  equals `{addr[26:4], 4'b0000}`.
- `app_cmd`  out  3  3'b001 = read, 3'b000 = write.
- `app_en`  out  1  command valid.
- `app_rdy`  in  1  command accepted when `app_en && app_rdy`.
- `app_wdf_data`  out  128  write data.
- `app_wdf_wren`  out  1  write-data valid.
- `app_wdf_end`  out  1  always equal to `app_wdf_wren`; single-beat line.
- `app_wdf_mask`  out  16  constant 0.
- `app_wdf_rdy`  in  1  write data accepted when `app_wdf_wren && app_wdf_rdy`.
- `app_rd_data`  in  128  read return data.
- `app_rd_data_valid`  in  1  read return strobe.
- `err_overrun`  out  1  sticky flag: a request arrived while the same-type request was already pending or in service.

## Operation
- **Request latches.** Two request latches, rd and wr. Each holds a pend bit, the address, and for wr the data. Each is loaded on its `_en` pulse.
- **Overrun.** If `_en` arrives while that channel is pending or in service, the request is dropped, `err_overrun` is set, and the original request continues unaffected.
- **States.**
  - IDLE: waits for `init_calib_complete=1` and at least one pend bit. Goes to RD_CMD or WR_CMD per arbitration.
  - RD_CMD: drives `app_en=1`, `app_cmd=001` and the latched address. On `app_rdy`, goes to RD_WAIT and drops `app_en` the next cycle.
  - RD_WAIT: on `app_rd_data_valid`, captures `app_rd_data`, pulses `DDR2cache_rd_fin` the next cycle, clears rd pend, and returns to IDLE.
  - WR_CMD: drives `app_en` with `app_cmd=000` and `app_wdf_wren` with the data, both in the same first cycle. Each signal deasserts independently the cycle after its own ready is seen. When both have been accepted (same or different cycles), pulses `DDR2cache_wr_fin` the next cycle, clears wr pend, and returns to IDLE.
- **Single-pending case.** If only one request is pending, it is served.
- **Arbitration.** Applied at IDLE only. A request latched during service waits for IDLE.
- **Read-data hazard.** `app_rd_data_valid` outside RD_WAIT is ignored.

## Timing
- **Reset values.** All outputs are 0, `app_cmd` is 3'b000, state is IDLE, pend bits are 0, and `err_overrun` is 0. Reset mid-transaction abandons it silently and no `fin` is produced.
- **Read path.**
  - `rd_en` in cycle 0 sets pend in cycle 1.
  - IDLE decides in cycle 1, and `app_en` is high in cycle 2.
  - With `app_rdy=1` in cycle 2, `app_en` is low in cycle 3.
  - `app_rd_data_valid` in cycle k gives `DDR2cache_rd_fin=1` in cycle k+1.
- **Write path.**
  - `wr_en` in cycle 0 drives `app_en`/`app_wdf_wren` high in cycle 2.
  - With both readies high in cycle 2, `DDR2cache_wr_fin=1` in cycle 3.
- **Stalls.** `app_en`/`app_wdf_wren` stay high and unchanged across any number of not-ready cycles.
- **Back-to-back.** After a `fin` cycle, a further pending request has its command out 2 cycles after that `fin` cycle (fin→IDLE→CMD).
- **Simultaneous pulses.** `rd_en` and `wr_en` in the same cycle are both latched; the order follows Configuration.
- **Ready before valid.** A ready seen before the matching valid has no effect.

## Configuration
- `DDR_ARB_RD_FIRST_EN` defined: a pending read beats a pending write. Gives lower fill latency; the cache must not read a line with an outstanding write.
- Undefined (default): a pending write beats a pending read, which preserves write→read ordering to the same line.
- Only the IDLE tie-break changes; all timing is identical.

## Test plan
- **Read.** `rd_en` with addr 27'h0001234; `app_rdy=1`; return data 128'hA5.. 3 cycles after acceptance. Expect `app_addr=27'h0001230` and `app_cmd=001`, then exactly one `DDR2cache_rd_fin` carrying the same data.
- **Write with split readies.** `wr_en` with addr 27'h0000040 and data 128'h1111..; `app_rdy` low for 4 cycles, `app_wdf_rdy` high immediately. Expect `app_wdf_wren` for 1 cycle, `app_en` for 5 cycles, and a single `wr_fin` the cycle after the 5th.
- **Simultaneous pulses.** `rd_en` and `wr_en` in the same cycle. Default build: write command first, then read. Macro build: read command first. Both `fin` pulses occur, one each.
- **Calibration gating and overrun.** With `init_calib_complete=0`, send `rd_en` twice. Expect no `app_en` and `err_overrun=1`. Raise calib; exactly one read is issued, at the first address.
- **Reset mid-read.** Assert `rst` in RD_WAIT. Expect all outputs 0 and no `rd_fin`, even if `app_rd_data_valid` arrives afterwards. A new `rd_en` after reset completes normally.
